hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage core: detects load-use and control hazards, generates E-stage forwarding selects, and sequences stall/flush of the F/D/E/M pipeline registers.
- Uses the decode-stage immediate-select encoding to know which source registers an instruction actually reads.
- Freezes the whole pipe during data-memory wait cycles and flags a memory timeout.
- Keeps saturating performance counters for stalls, flushes and memory-wait cycles.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/fwd_sel.sv | 21 ++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the core: decode immediate selects, E-stage forward selects
// and the hazard controller state type.
package riscv_pkg;

   localparam logic [2:0] IMM_I   = 3'b000;
   localparam logic [2:0] IMM_B   = 3'b001;
   localparam logic [2:0] IMM_J   = 3'b010;
   localparam logic [2:0] IMM_S   = 3'b011;
   localparam logic [2:0] IMM_U   = 3'b100;
   localparam logic [2:0] IMM_R   = 3'b101;
   localparam logic [2:0] IMM_PC4 = 3'b110;
   localparam logic [2:0] IMM_R2  = 3'b111;

   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hz_state_e;

   // J, U and PC+4 forms take no rs1 operand
   function automatic logic src1_used(input logic [2:0] imm_sel);
      return !(imm_sel == IMM_J || imm_sel == IMM_U || imm_sel == IMM_PC4);
   endfunction

   function automatic logic src2_used(input logic [2:0] imm_sel);
      return (imm_sel == IMM_B || imm_sel == IMM_S || imm_sel == IMM_R || imm_sel == IMM_R2);
   endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one E-stage source; the M stage wins over W.
import riscv_pkg::*;

module fwd_sel (
   input  logic [4:0] rs,
   input  logic [4:0] rd_m,
   input  logic [4:0] rd_w,
   input  logic       reg_write_m,
   input  logic       reg_write_w,
   output logic [1:0] sel
);

   always_comb begin
      sel = FWD_RF;
      if (reg_write_m && rd_m != 5'd0 && rd_m == rs)
         sel = FWD_M;
      else if (reg_write_w && rd_w != 5'd0 && rd_w == rs)
         sel = FWD_W;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/branch stall-flush sequencing, forwarding
// selects, data-memory wait freeze with timeout, saturating performance counters.
import riscv_pkg::*;

module hazard_ctrl #(
   parameter int CNT_W    = 16,
   parameter int MAX_WAIT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1D,
   input  logic [4:0]       rs2D,
   input  logic [2:0]       immSelD,
   input  logic [4:0]       rs1E,
   input  logic [4:0]       rs2E,
   input  logic [4:0]       rdE,
   input  logic             resultSrcE0,
   input  logic             pcSrcE,
   input  logic [4:0]       rdM,
   input  logic [4:0]       rdW,
   input  logic             regWriteM,
   input  logic             regWriteW,
   input  logic             dmemBusyM,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             flushD,
   output logic             flushE,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             memTimeout,
   output logic [CNT_W-1:0] stallCnt,
   output logic [CNT_W-1:0] flushCnt,
   output logic [CNT_W-1:0] memWaitCnt
);

   localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_INC   = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
   localparam logic [CNT_W-1:0]  CNT_INC    = CNT_W'(1);

   hz_state_e         state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              load_use;

   assign load_use = resultSrcE0 && rdE != 5'd0 &&
                     ((src1_used(immSelD) && rs1D == rdE) ||
                      (src2_used(immSelD) && rs2D == rdE));

   fwd_sel u_fwd_a (
      .rs(rs1E), .rd_m(rdM), .rd_w(rdW),
      .reg_write_m(regWriteM), .reg_write_w(regWriteW), .sel(forwardAE)
   );

   fwd_sel u_fwd_b (
      .rs(rs2E), .rd_m(rdM), .rd_w(rdW),
      .reg_write_m(regWriteM), .reg_write_w(regWriteW), .sel(forwardBE)
   );

   always_comb begin
      stallF  = 1'b0;
      stallD  = 1'b0;
      stallE  = 1'b0;
      stallM  = 1'b0;
      flushD  = 1'b0;
      flushE  = 1'b0;
      state_d = state_q;
      wait_d  = '0;

      case (state_q)
         ST_RUN:      if (dmemBusyM)  state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: if (!dmemBusyM) state_d = ST_RUN;
         default:                     state_d = ST_RUN;
      endcase

      // wait counter parks at the limit so it cannot wrap during a long stall
      if (dmemBusyM)
         wait_d = (wait_q == WAIT_LIMIT) ? wait_q : wait_q + WAIT_INC;

      if (rst) begin
         flushD = 1'b1;
         flushE = 1'b1;
      end else if (dmemBusyM) begin
         // memory freeze holds everything; pending branch flush replays on release
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         stallM = 1'b1;
      end else begin
         stallF = load_use && !pcSrcE;
         stallD = load_use && !pcSrcE;
         flushD = pcSrcE;
         flushE = pcSrcE || load_use;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_RUN;
         wait_q     <= '0;
         memTimeout <= 1'b0;
         stallCnt   <= '0;
         flushCnt   <= '0;
         memWaitCnt <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (wait_d == WAIT_LIMIT)
            memTimeout <= 1'b1;
         if (stallD && !dmemBusyM && stallCnt != CNT_MAX)
            stallCnt <= stallCnt + CNT_INC;
         if (flushD && flushCnt != CNT_MAX)
            flushCnt <= flushCnt + CNT_INC;
         if (dmemBusyM && memWaitCnt != CNT_MAX)
            memWaitCnt <= memWaitCnt + CNT_INC;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic,
// expectations from a behavioural model of the controller's rules.
module tb_hazard_ctrl;

   localparam int CNT_W    = 2;
   localparam int MAX_WAIT = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst;
   logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic [2:0]       immSelD;
   logic             resultSrcE0, pcSrcE, regWriteM, regWriteW, dmemBusyM;
   logic             stallF, stallD, stallE, stallM, flushD, flushE, memTimeout;
   logic [1:0]       forwardAE, forwardBE;
   logic [CNT_W-1:0] stallCnt, flushCnt, memWaitCnt;

   hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst(rst),
      .rs1D(rs1D), .rs2D(rs2D), .immSelD(immSelD),
      .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
      .resultSrcE0(resultSrcE0), .pcSrcE(pcSrcE),
      .rdM(rdM), .rdW(rdW), .regWriteM(regWriteM), .regWriteW(regWriteW),
      .dmemBusyM(dmemBusyM),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE),
      .forwardAE(forwardAE), .forwardBE(forwardBE),
      .memTimeout(memTimeout),
      .stallCnt(stallCnt), .flushCnt(flushCnt), .memWaitCnt(memWaitCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit       rst;
      bit [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
      bit [2:0] imm;
      bit       ld, pc, wM, wW, busy;
   } stim_t;

   typedef struct {
      int st_f, st_d, st_e, st_m, fl_d, fl_e, fwd_a, fwd_b;
      int timeout, c_stall, c_flush, c_mw, state;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   // model of the registered state: counters, wait length, sticky flag, freeze state
   int m_stall = 0, m_flush = 0, m_mw = 0, m_wait = 0, m_to = 0, m_state = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int fwd_of(input bit [4:0] rs, input stim_t s);
      if (s.wM && s.rdM != 0 && s.rdM == rs) return 2;
      if (s.wW && s.rdW != 0 && s.rdW == rs) return 1;
      return 0;
   endfunction

   function automatic exp_t predict(input stim_t s);
      exp_t e;
      bit   uses1, uses2, lu;
      uses1 = !(s.imm inside {3'd2, 3'd4, 3'd6});
      uses2 = s.imm inside {3'd1, 3'd3, 3'd5, 3'd7};
      lu = s.ld && s.rdE != 0 && ((uses1 && s.rs1D == s.rdE) || (uses2 && s.rs2D == s.rdE));
      e.fwd_a = fwd_of(s.rs1E, s);
      e.fwd_b = fwd_of(s.rs2E, s);
      if (s.rst) begin
         e.st_f = 0; e.st_d = 0; e.st_e = 0; e.st_m = 0; e.fl_d = 1; e.fl_e = 1;
      end else if (s.busy) begin
         e.st_f = 1; e.st_d = 1; e.st_e = 1; e.st_m = 1; e.fl_d = 0; e.fl_e = 0;
      end else begin
         e.st_f = int'(lu && !s.pc); e.st_d = e.st_f; e.st_e = 0; e.st_m = 0;
         e.fl_d = int'(s.pc); e.fl_e = int'(s.pc || lu);
      end
      e.timeout = m_to; e.c_stall = m_stall; e.c_flush = m_flush;
      e.c_mw = m_mw; e.state = m_state;
      return e;
   endfunction

   task automatic issue(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      rst = s.rst; rs1D = s.rs1D; rs2D = s.rs2D; immSelD = s.imm;
      rs1E = s.rs1E; rs2E = s.rs2E; rdE = s.rdE; resultSrcE0 = s.ld; pcSrcE = s.pc;
      rdM = s.rdM; rdW = s.rdW; regWriteM = s.wM; regWriteW = s.wW; dmemBusyM = s.busy;
      e = predict(s);
      q.push_back(e);
      if (s.rst) begin
         m_stall = 0; m_flush = 0; m_mw = 0; m_wait = 0; m_to = 0; m_state = 0;
      end else begin
         if (e.st_d == 1 && !s.busy && m_stall < CNT_MAX) m_stall++;
         if (e.fl_d == 1 && m_flush < CNT_MAX) m_flush++;
         if (s.busy && m_mw < CNT_MAX) m_mw++;
         if (s.busy) begin
            if (m_wait < MAX_WAIT) m_wait++;
            if (m_wait >= MAX_WAIT) m_to = 1;
         end else begin
            m_wait = 0;
         end
         m_state = int'(s.busy);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("stallF", 32'(stallF), e.st_f);
         chk("stallD", 32'(stallD), e.st_d);
         chk("stallE", 32'(stallE), e.st_e);
         chk("stallM", 32'(stallM), e.st_m);
         chk("flushD", 32'(flushD), e.fl_d);
         chk("flushE", 32'(flushE), e.fl_e);
         chk("forwardAE", 32'(forwardAE), e.fwd_a);
         chk("forwardBE", 32'(forwardBE), e.fwd_b);
         chk("memTimeout", 32'(memTimeout), e.timeout);
         chk("stallCnt", 32'(stallCnt), e.c_stall);
         chk("flushCnt", 32'(flushCnt), e.c_flush);
         chk("memWaitCnt", 32'(memWaitCnt), e.c_mw);
         chk("state", 32'(dut.state_q), e.state);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

   initial begin
      stim_t s;
      bit    busy_r = 0;
      rst = 1'b1; rs1D = '0; rs2D = '0; immSelD = '0; rs1E = '0; rs2E = '0; rdE = '0;
      resultSrcE0 = 1'b0; pcSrcE = 1'b0; rdM = '0; rdW = '0;
      regWriteM = 1'b0; regWriteW = 1'b0; dmemBusyM = 1'b0;
      repeat (2) @(posedge clk);

      s = idle(); s.rst = 1; issue(s);

      // load-use on rs1 with I-type, then the same with U-type (no rs1 read)
      s = idle(); s.ld = 1; s.rdE = 5; s.rs1D = 5; s.imm = 3'b000; issue(s);
      s.imm = 3'b100; issue(s);

      // forwarding priority on operand B
      s = idle(); s.wM = 1; s.wW = 1; s.rdM = 7; s.rdW = 7; s.rs2E = 7; issue(s);
      s.rdM = 0; issue(s);
      s.rdW = 0; s.rs2E = 0; s.rdM = 7; issue(s);

      // taken branch beats load-use
      s = idle(); s.ld = 1; s.rdE = 5; s.rs1D = 5; s.pc = 1; issue(s);
      s = idle(); issue(s);

      // memory wait with a pending branch, then release
      s = idle(); s.pc = 1; s.busy = 1;
      repeat (3) issue(s);
      s.busy = 0; issue(s);
      s = idle(); issue(s);

      // timeout: six busy cycles, sticky afterwards, cleared by reset
      s = idle(); s.busy = 1;
      repeat (6) issue(s);
      s = idle(); repeat (2) issue(s);
      s.rst = 1; issue(s);
      s = idle(); issue(s);

      // reset in the middle of a memory wait
      s = idle(); s.busy = 1; repeat (2) issue(s);
      s.rst = 1; issue(s);
      s = idle(); issue(s);

      // five load-use stalls saturate the stall counter
      s = idle(); s.ld = 1; s.rdE = 3; s.rs2D = 3; s.imm = 3'b011;
      repeat (5) issue(s);

      for (int i = 0; i < 2000; i++) begin
         s = idle();
         s.rst  = ($urandom_range(0, 59) == 0);
         s.rs1D = 5'($urandom_range(0, 7)); s.rs2D = 5'($urandom_range(0, 7));
         s.rs1E = 5'($urandom_range(0, 7)); s.rs2E = 5'($urandom_range(0, 7));
         s.rdE  = 5'($urandom_range(0, 7)); s.rdM  = 5'($urandom_range(0, 7));
         s.rdW  = 5'($urandom_range(0, 7)); s.imm  = 3'($urandom_range(0, 7));
         s.ld   = ($urandom_range(0, 1) == 1);
         s.pc   = ($urandom_range(0, 3) == 0);
         s.wM   = ($urandom_range(0, 3) != 0);
         s.wW   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 4) == 0) busy_r = !busy_r;
         s.busy = busy_r;
         issue(s);
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
